// File: rtl/dmem_pkg.sv
// Shared encodings for the load/store data memory.
// Size codes, FSM states, error bit positions and lane enables.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [3:0] byte_en(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      (sz == SZ_BYTE): be = 4'b0001 << lo;
      (sz == SZ_HALF): be = 4'b0011 << {lo[1], 1'b0};
      (sz == SZ_WORD): be = 4'b1111;
      default:         be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_array.sv
// Byte-lane word array: async clear, per-lane write, comb read.
// Word 0 low half is tapped out for observation.
module dmem_lane_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [15:0]   test_value
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata      = mem_q[idx];
  assign test_value = mem_q[0][15:0];

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit front end: handshake FSM, latency counter,
// lane steering, load extension and request error checks.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [15:0] test_value
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [30:0] DEPTH = 31'(DEPTH_WORDS);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [IW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    err_q;
  logic          resp_valid_q;
  logic [31:0]   resp_rdata_q;
  logic [1:0]    resp_err_q;

  logic        mis_c;
  logic        oor_c;
  logic [1:0]  err_c;
  logic        arr_we;
  logic [3:0]  arr_be;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata;
  logic [31:0] sh_c;
  logic [31:0] ld_c;
  logic        go_c;

  always_comb begin
    mis_c = 1'b0;
    unique case (1'b1)
      (req_size == SZ_BYTE): mis_c = 1'b0;
      (req_size == SZ_HALF): mis_c = req_addr[0];
      (req_size == SZ_WORD): mis_c = |req_addr[1:0];
      default:               mis_c = 1'b1;
    endcase
    oor_c = ({1'b0, req_addr[31:2]} >= DEPTH);
    err_c = '0;
    err_c[ERR_MISALIGN] = mis_c;
    err_c[ERR_RANGE]    = oor_c;
  end

  assign go_c   = (state_q == WAIT) && (cnt_q == '0);
  assign arr_we = go_c && we_q;
  assign arr_be = byte_en(size_q, addr_q[1:0]);

  always_comb begin
    arr_wdata = wdata_q;
    unique case (1'b1)
      (size_q == SZ_BYTE): arr_wdata = {4{wdata_q[7:0]}};
      (size_q == SZ_HALF): arr_wdata = {2{wdata_q[15:0]}};
      default:             arr_wdata = wdata_q;
    endcase
  end

  dmem_lane_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .we         (arr_we),
    .be         (arr_be),
    .idx        (addr_q[IW+1:2]),
    .wdata      (arr_wdata),
    .rdata      (arr_rdata),
    .test_value (test_value)
  );

  // Halfwords are aligned, so a byte-granular shift serves both sizes.
  assign sh_c = arr_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_c = arr_rdata;
    unique case (1'b1)
      (size_q == SZ_BYTE): ld_c = {{24{~uns_q & sh_c[7]}}, sh_c[7:0]};
      (size_q == SZ_HALF): ld_c = {{16{~uns_q & sh_c[15]}}, sh_c[15:0]};
      default:             ld_c = arr_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr[IW+1:0];
            wdata_q <= req_wdata;
            err_q   <= err_c;
            if (|err_c) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= we_q ? 32'd0 : ld_c;
            resp_err_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          // Errored requests arrive here without a strobe yet.
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= err_q;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised load/store data memory for the MIPS datapath. It replaces the fixed 100-word, word-indexed, zero-latency store with a byte-addressed array of configurable depth. It supports byte, halfword and word accesses with sign or zero extension, runs each request through a valid/ready handshake with programmable access latency, and flags misaligned or out-of-range requests. It sits between the ALU address/rt write-data path and the writeback mux, and keeps the 16-bit test observation port.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array, from 1 to 2^30.
- LATENCY, 2: cycles from request accept to response. Must be ≥1.
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- req_valid, input, 1: a request is present.
- req_ready, output, 1: the block can accept a request. High only in IDLE.
- req_we, input, 1: 1 for store, 0 for load.
- req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned, input, 1: zero-extend loads (lbu/lhu). Ignored for word accesses and stores.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data, right-aligned.
- resp_valid, output, 1: one-cycle response strobe.
- resp_rdata, output, 32: load result, extended. Forced to 0 for stores and errors.
- resp_err, output, 2: bit0 misaligned, bit1 out of range.
- test_value, output, 16: word 0, bits [15:0], combinational.

## Operation
- Word index = req_addr[31:2]. Lane n = addr[1:0] maps to bits [8n+7:8n] (little-endian).
- Misaligned: halfword with addr[0]=1, word with addr[1:0]≠0, or any req_size=11.
- Out of range: word index ≥ DEPTH_WORDS. Both error bits may be set together.
- Errored requests never write the array.
- Store byte: writes wdata[7:0] to lane addr[1:0].
- Store halfword: writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
- Store word: writes all four lanes.
- Lanes not selected by a store are left unchanged.
- Loads select the same lanes, then sign- or zero-extend per req_unsigned.
- State machine, three states:
  - IDLE: on req_valid, capture all request fields and error bits. With no error, go to WAIT with cnt=LATENCY-1. With an error, go straight to RESP.
  - WAIT: if cnt=0, perform the array access and register resp_rdata, then go to RESP. Otherwise decrement cnt.
  - RESP: resp_valid=1 for one cycle, then return to IDLE unconditionally. There is no response back-pressure.
- Reset:
  - Array cleared to 0.
  - State goes to IDLE and cnt to 0.
  - resp_valid, resp_rdata and resp_err go to 0.
  - req_ready is 1 once reset is removed.
- Reset mid-operation: the outstanding request is dropped with no response, and any pending write is lost.

## Timing
- Accept on rising edge k, where req_valid and req_ready are both high.
- Good request: array read and write happen at edge k+LATENCY. resp_valid is high in the cycle after edge k+LATENCY. req_ready is high again after edge k+LATENCY+1.
- Errored request: resp_valid follows edge k+1, and req_ready returns after edge k+2.
- Throughput: one request per LATENCY+2 cycles.
- test_value reflects a store to word 0 in the cycle following the write edge.
- resp_rdata and resp_err are stable only while resp_valid is high. Otherwise they hold their last value.

## Structure
- Shared package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum IDLE/WAIT/RESP
  - ERR_MISALIGN=0 and ERR_RANGE=1 bit positions
- Sub-module dmem_lane_array:
  - DEPTH_WORDS×32 storage
  - 4-bit byte write enable
  - asynchronous clear on rst
  - combinational read port
  - test_value tap
- The top level holds the FSM, latency counter, lane steering, extension and error checks.

## Test plan
- Reset, then sw 0x12345678 @0x0, then lw @0x0 with LATENCY=2: resp_valid 3 cycles after the accept edge, rdata=0x12345678, err=0, test_value=0x5678.
- sb 0xAB @0x5, then lb @0x5 → 0xFFFFFFAB. lbu @0x5 → 0x000000AB. lw @0x4 → 0x0000AB00.
- sh 0x8001 @0x2 over word 0 = 0x12345678, then lw @0x0 → 0x80015678. lh @0x2 → 0xFFFF8001.
- lw @0x2 → err=01, rdata=0, resp one edge after accept. sw @4·DEPTH_WORDS → err=10, and a following lw of every word shows no change.
- Hold req_valid high continuously: req_ready low from the accept until after the response, and exactly one accept per LATENCY+2 cycles.
- Drop rst low during WAIT after sw 0xFFFFFFFF @0x8: no resp_valid, and after release lw @0x8 → 0, req_ready=1.
